// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the weight DMA read arbiter.
// Holds the FSM state encoding, default widths and a clog2 helper for sizing owner indices.
package dma_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StXfer  = 2'd2
   } arb_state_e;

   localparam int unsigned DefAddrW = 27;
   localparam int unsigned DefLenW  = 27;
   localparam int unsigned DefDataW = 512;

   // Never returns 0 so a single-requester build still gets a 1-bit index.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) begin
         r++;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// valid_o is low when no request is set; idx_o is then zero.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic             valid_o,
   output logic [ID_W-1:0]  idx_o
);

   int unsigned      j;
   logic [ID_W-1:0]  cand;

   // Walk offsets from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      cand    = '0;
      for (int unsigned k = N_REQ; k > 0; k--) begin
         j    = (32'(ptr_i) + k - 1) % N_REQ;
         cand = ID_W'(j);
         if (req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one weight DMA read engine among N_REQ
// layer controllers; forwards the owner's request and steers returned beats back to it.
module dma_rd_arbiter
   import dma_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ID_W   = clog2(N_REQ),
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned LEN_W  = DefLenW,
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        layer_req,
   input  logic [N_REQ*ADDR_W-1:0] layer_start_addr,
   input  logic [N_REQ*LEN_W-1:0]  layer_length,
   output logic [N_REQ-1:0]        layer_ack,
   output logic [DATA_W-1:0]       layer_dout,
   output logic [N_REQ-1:0]        layer_dout_en,
   output logic [N_REQ-1:0]        layer_dout_eop,
   output logic                    dma_req,
   input  logic                    dma_ack,
   output logic [ADDR_W-1:0]       dma_start_addr,
   output logic [LEN_W-1:0]        dma_length,
   input  logic [DATA_W-1:0]       dma_dout,
   input  logic                    dma_dout_en,
   input  logic                    dma_dout_eop,
   output logic                    busy,
   output logic [ID_W-1:0]         owner,
   output logic                    err_spurious
);

   arb_state_e         state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               dma_req_q, dma_req_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic [N_REQ-1:0]   dout_en_q, dout_en_d;
   logic [N_REQ-1:0]   dout_eop_q, dout_eop_d;
   logic               err_q, err_d;

   logic               pick_valid;
   logic [ID_W-1:0]    pick_idx;
   logic               in_window;
   logic               beat_last;
   logic [ID_W-1:0]    next_ptr;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req_i   (layer_req),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // The ack cycle of ISSUE already belongs to the grant so single-beat transfers land.
   assign in_window = (state_q == StXfer) || ((state_q == StIssue) && dma_ack);
   assign beat_last = dma_dout_en & dma_dout_eop;
   assign next_ptr  = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      len_d      = len_q;
      dma_req_d  = dma_req_q;
      ack_d      = '0;
      dout_d     = dout_q;
      dout_en_d  = '0;
      dout_eop_d = '0;
      err_d      = err_q;

      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               owner_d   = pick_idx;
               addr_d    = layer_start_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
               len_d     = layer_length[32'(pick_idx) * LEN_W +: LEN_W];
               dma_req_d = 1'b1;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            if (dma_ack) begin
               dma_req_d       = 1'b0;
               ack_d[owner_q]  = 1'b1;
               if (beat_last) begin
                  state_d  = StIdle;
                  rr_ptr_d = next_ptr;
               end else begin
                  state_d  = StXfer;
               end
            end
         end
         StXfer: begin
            if (beat_last) begin
               state_d  = StIdle;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = StIdle;
      endcase

      if (dma_dout_en) begin
         if (in_window) begin
            dout_d              = dma_dout;
            dout_en_d[owner_q]  = 1'b1;
            dout_eop_d[owner_q] = dma_dout_eop;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         dma_req_q  <= 1'b0;
         ack_q      <= '0;
         dout_q     <= '0;
         dout_en_q  <= '0;
         dout_eop_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         dma_req_q  <= dma_req_d;
         ack_q      <= ack_d;
         dout_q     <= dout_d;
         dout_en_q  <= dout_en_d;
         dout_eop_q <= dout_eop_d;
         err_q      <= err_d;
      end
   end

   assign busy           = (state_q != StIdle);
   assign owner          = owner_q;
   assign dma_req        = dma_req_q;
   assign dma_start_addr = addr_q;
   assign dma_length     = len_q;
   assign layer_ack      = ack_q;
   assign layer_dout     = dout_q;
   assign layer_dout_en  = dout_en_q;
   assign layer_dout_eop = dout_eop_q;
   assign err_spurious   = err_q;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Randomized bench for dma_rd_arbiter: plays the layer controllers and the DMA engine and
// predicts grants, beat steering and error flags from a transaction-level model.
module tb_dma_rd_arbiter;

   localparam int N  = 4;
   localparam int AW = 27;
   localparam int LW = 27;
   localparam int DW = 512;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    layer_req;
   logic [N*AW-1:0] layer_start_addr;
   logic [N*LW-1:0] layer_length;
   logic [N-1:0]    layer_ack;
   logic [DW-1:0]   layer_dout;
   logic [N-1:0]    layer_dout_en;
   logic [N-1:0]    layer_dout_eop;
   logic            dma_req;
   logic            dma_ack;
   logic [AW-1:0]   dma_start_addr;
   logic [LW-1:0]   dma_length;
   logic [DW-1:0]   dma_dout;
   logic            dma_dout_en;
   logic            dma_dout_eop;
   logic            busy;
   logic [1:0]      owner;
   logic            err_spurious;

   always #5 clk = ~clk;

   dma_rd_arbiter #(
      .N_REQ  (N),
      .ID_W   (2),
      .ADDR_W (AW),
      .LEN_W  (LW),
      .DATA_W (DW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .layer_req        (layer_req),
      .layer_start_addr (layer_start_addr),
      .layer_length     (layer_length),
      .layer_ack        (layer_ack),
      .layer_dout       (layer_dout),
      .layer_dout_en    (layer_dout_en),
      .layer_dout_eop   (layer_dout_eop),
      .dma_req          (dma_req),
      .dma_ack          (dma_ack),
      .dma_start_addr   (dma_start_addr),
      .dma_length       (dma_length),
      .dma_dout         (dma_dout),
      .dma_dout_en      (dma_dout_en),
      .dma_dout_eop     (dma_dout_eop),
      .busy             (busy),
      .owner            (owner),
      .err_spurious     (err_spurious)
   );

   int            checks = 0;
   int            errors = 0;
   logic [N-1:0]  pend;
   logic [AW-1:0] r_addr [N];
   logic [LW-1:0] r_len  [N];
   int            exp_ptr;

   assign layer_req = pend;

   always_comb begin
      layer_start_addr = '0;
      layer_length     = '0;
      for (int i = 0; i < N; i++) begin
         layer_start_addr[i*AW +: AW] = r_addr[i];
         layer_length[i*LW +: LW]     = r_len[i];
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Next grant: nearest pending requester at or after the pointer, modulo N.
   function automatic int exp_owner();
      for (int k = 0; k < N; k++) begin
         if (pend[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic raise(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
      if (!pend[i]) begin
         pend[i]   = 1'b1;
         r_addr[i] = a;
         r_len[i]  = l;
      end
   endtask

   task automatic raise_mask(input logic [N-1:0] m);
      for (int i = 0; i < N; i++) begin
         if (m[i]) raise(i, AW'($urandom), LW'($urandom));
      end
   endtask

   // Called with the DUT idle and requests already driven this cycle.
   task automatic xfer(input int nbeats, input int ack_dly, input int gap_max,
                       input logic [N-1:0] add_mask, input bit one_shot, output int o);
      logic [DW-1:0] d;
      logic [N-1:0]  oh;
      int            left;
      o = exp_owner();
      if (o < 0) begin
         chk("have_req", 0, 1);
         return;
      end
      oh = N'(1 << o);
      tick();
      chk("dma_req_rise", dma_req, 1);
      chk("owner", owner, o);
      chk("dma_addr", dma_start_addr, r_addr[o]);
      chk("dma_len", dma_length, r_len[o]);
      chk("busy_grant", busy, 1);
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         chk("dma_req_hold", dma_req, 1);
         chk("no_early_ack", layer_ack, 0);
      end
      dma_ack = 1'b1;
      pend[o] = 1'b0;
      left    = nbeats;
      d       = '0;
      if (one_shot) begin
         d            = rnd_data();
         dma_dout     = d;
         dma_dout_en  = 1'b1;
         dma_dout_eop = 1'b1;
         raise_mask(add_mask);
         left         = 0;
      end
      tick();
      dma_ack      = 1'b0;
      dma_dout_en  = 1'b0;
      dma_dout_eop = 1'b0;
      chk("layer_ack", layer_ack, oh);
      chk("dma_req_drop", dma_req, 0);
      if (one_shot) begin
         chk("dout_1beat", layer_dout, d);
         chk("en_1beat", layer_dout_en, oh);
         chk("eop_1beat", layer_dout_eop, oh);
         chk("idle_1beat", busy, 0);
      end else begin
         chk("en_at_ack", layer_dout_en, 0);
      end
      for (int b = 0; b < left; b++) begin
         int gaps;
         gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int g = 0; g < gaps; g++) begin
            tick();
            chk("en_gap", layer_dout_en, 0);
         end
         d            = rnd_data();
         dma_dout     = d;
         dma_dout_en  = 1'b1;
         dma_dout_eop = (b == left - 1);
         if (b == left - 1) raise_mask(add_mask);
         tick();
         dma_dout_en  = 1'b0;
         dma_dout_eop = 1'b0;
         chk("dout", layer_dout, d);
         chk("dout_en", layer_dout_en, oh);
         chk("dout_eop", layer_dout_eop, (b == left - 1) ? oh : '0);
         chk("ack_once", layer_ack, 0);
      end
      chk("idle_after_eop", busy, 0);
      chk("bubble", dma_req, 0);
      exp_ptr = (o + 1) % N;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int            o;
      int            rr_exp [5] = '{0, 1, 2, 3, 0};
      logic [DW-1:0] prev;

      rst          = 1'b0;
      pend         = '0;
      dma_ack      = 1'b0;
      dma_dout     = '0;
      dma_dout_en  = 1'b0;
      dma_dout_eop = 1'b0;
      exp_ptr      = 0;
      for (int i = 0; i < N; i++) begin
         r_addr[i] = '0;
         r_len[i]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_dma_req", dma_req, 0);
      chk("rst_owner", owner, 0);
      chk("rst_err", err_spurious, 0);
      chk("rst_ack", layer_ack, 0);
      chk("rst_en", layer_dout_en, 0);
      chk("rst_dout", layer_dout, 0);
      rst = 1'b1;
      tick();

      // All four requesting; requester 0 re-requests at the end of its own grant.
      for (int i = 0; i < N; i++) raise(i, AW'(1000 + i), LW'(4));
      for (int k = 0; k < 5; k++) begin
         xfer(4, 1, 0, (k == 0) ? 4'b0001 : 4'b0000, 1'b0, o);
         chk("rr_order", o, rr_exp[k]);
      end

      raise(1, AW'(2500), LW'(128));
      xfer(128, 3, 0, 4'b0000, 1'b0, o);
      chk("single_owner", o, 1);
      chk("addr_hold", dma_start_addr, 2500);
      chk("len_hold", dma_length, 128);

      raise(2, AW'($urandom), LW'(1));
      xfer(1, 0, 0, 4'b0000, 1'b1, o);
      chk("oneshot_owner", o, 2);

      for (int t = 0; t < 40; t++) begin
         int nb;
         if (pend == '0) raise(int'($urandom_range(N - 1, 0)), AW'($urandom), LW'($urandom));
         nb = int'($urandom_range(5, 1));
         xfer(nb, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
              N'($urandom), (nb == 1) && $urandom_range(1, 0) == 1, o);
      end
      for (int t = 0; t < N; t++) begin
         if (pend != '0) xfer(1, 0, 0, 4'b0000, 1'b0, o);
      end
      chk("no_spur_yet", err_spurious, 0);

      prev         = layer_dout;
      dma_dout     = rnd_data();
      dma_dout_en  = 1'b1;
      dma_dout_eop = 1'b1;
      tick();
      dma_dout_en  = 1'b0;
      dma_dout_eop = 1'b0;
      chk("spur_en", layer_dout_en, 0);
      chk("spur_err", err_spurious, 1);
      chk("spur_dout_hold", layer_dout, prev);
      chk("spur_idle", busy, 0);
      repeat (3) tick();
      chk("spur_sticky", err_spurious, 1);

      // Reset lands during the fifth beat of a 128-beat grant to requester 2.
      raise(2, AW'(77), LW'(128));
      tick();
      chk("mid_req", dma_req, 1);
      dma_ack = 1'b1;
      pend[2] = 1'b0;
      tick();
      dma_ack = 1'b0;
      for (int b = 0; b < 4; b++) begin
         dma_dout    = rnd_data();
         dma_dout_en = 1'b1;
         tick();
         chk("mid_en", layer_dout_en, 4'b0100);
      end
      dma_dout = rnd_data();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_dma_req", dma_req, 0);
      chk("arst_en", layer_dout_en, 0);
      chk("arst_eop", layer_dout_eop, 0);
      chk("arst_ack", layer_ack, 0);
      chk("arst_err", err_spurious, 0);
      chk("arst_owner", owner, 0);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      exp_ptr      = 0;
      dma_dout_en  = 1'b1;
      dma_dout_eop = 1'b0;
      tick();
      dma_dout_en  = 1'b0;
      chk("post_rst_en", layer_dout_en, 0);
      chk("post_rst_spur", err_spurious, 1);
      raise(3, AW'(333), LW'(2));
      raise(0, AW'(100), LW'(2));
      xfer(2, 1, 1, 4'b0000, 1'b0, o);
      chk("post_rst_owner", o, 0);
      xfer(2, 0, 0, 4'b0000, 1'b0, o);
      chk("post_rst_next", o, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_rd_arbiter.md
Name: dma_rd_arbiter

Overview:
- Shares the single 512-bit weight DMA read engine among N_REQ layer controllers (e.g. conv/ip layers running in parallel).
- Each controller keeps its existing req/ack/start_addr/length/dout_en/dout_eop handshake. The arbiter grants one owner at a time, forwards that owner's address and length to the engine, and steers returned beats only to the owner.
- Sits between the layer controllers and the DMA engine.
- Round-robin, non-preemptive; a grant lasts from request issue until the engine's eop.

Parameters:
- N_REQ, 4, number of requesting layer controllers
- ID_W, 2, owner index width, equal to clog2(N_REQ)
- ADDR_W, 27, DMA start-address width
- LEN_W, 27, DMA length width
- DATA_W, 512, DMA data beat width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-low
- layer_req  in  N_REQ  per-requester request level; held high until its layer_ack
- layer_start_addr  in  N_REQ*ADDR_W  packed; slice i belongs to requester i; stable while layer_req[i] is high
- layer_length  in  N_REQ*LEN_W  packed, same rules as layer_start_addr
- layer_ack  out  N_REQ  one-cycle acceptance pulse to the owner
- layer_dout  out  DATA_W  broadcast data, registered
- layer_dout_en  out  N_REQ  one-hot beat valid for the owner
- layer_dout_eop  out  N_REQ  one-hot last-beat flag for the owner
- dma_req  out  1  request to the DMA engine
- dma_ack  in  1  engine acceptance pulse
- dma_start_addr  out  ADDR_W  start address of the owner
- dma_length  out  LEN_W  length of the owner
- dma_dout  in  DATA_W  engine data
- dma_dout_en  in  1  engine beat valid
- dma_dout_eop  in  1  engine last beat; qualified by dma_dout_en
- busy  out  1  high outside IDLE
- owner  out  ID_W  current or last owner index
- err_spurious  out  1  sticky; set by a beat arriving with no valid grant

Behaviour:
- Reset (rst=0, async) forces:
  - state to IDLE and rr_ptr to 0
  - all outputs to 0, including err_spurious and owner
- Reset mid-transfer abandons the grant; remaining engine beats after reset release are spurious.
- FSM states: IDLE, ISSUE, XFER.
- IDLE:
  - If any layer_req is set, pick the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Register owner, dma_start_addr and dma_length from that requester's slices.
  - dma_req is set at the next edge; go to ISSUE.
  - A request present at cycle t therefore gives dma_req high at t+1.
- ISSUE:
  - dma_req is held high.
  - On dma_ack: dma_req cleared and layer_ack[owner] pulsed high, both at the next edge, for exactly one cycle; go to XFER.
  - Withdrawal of layer_req during ISSUE is illegal and is ignored; the grant proceeds.
- XFER: wait for dma_dout_en & dma_dout_eop, then go to IDLE and set rr_ptr = owner+1 (wrapping).
- Grant window = XFER, or ISSUE in the cycle dma_ack is high.
  - A beat in the window gives, one cycle later: layer_dout = dma_dout, layer_dout_en = onehot(owner), layer_dout_eop = onehot(owner) & dma_dout_eop.
  - Latency is exactly 1 cycle.
  - A single-beat transfer (ack, en and eop in the same ISSUE cycle) goes directly to IDLE.
- Beat outside the grant window: dropped, err_spurious set to 1, state unchanged.
- Back-to-back: eop at cycle v gives IDLE at v+1, so the next dma_req is at v+2 (one bubble cycle).
- layer_dout holds its last value when no beat is present; only the en/eop vectors qualify it.
- dma_start_addr and dma_length hold after a grant until the next grant.
- Fairness: a requester waits at most N_REQ-1 grants.
- busy = (state != IDLE).

Decomposition:
- Package dma_arb_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, XFER=2)
  - default width constants (ADDR_W=27, LEN_W=27, DATA_W=512)
  - a clog2 function for ID_W
- One sub-module, rr_pick:
  - purely combinational
  - inputs are the request vector and rr_ptr
  - outputs are a valid flag and the selected index
  - instantiated once in the top FSM

Test Plan:
- Single requester: layer_req=4'b0010, addr slice1=2500, len=128; engine acks 3 cycles after dma_req and sends 128 beats. Required:
  - dma_start_addr=2500, dma_length=128
  - layer_ack[1] single pulse; layer_dout_en[1] high 128 times, each 1 cycle after the engine beat
  - layer_dout_eop[1] on the last beat; other bits stay 0
- Round-robin: all 4 requests held, 4-beat transfers. Required:
  - grants in order 0,1,2,3
  - requester 0 then re-requests and is granted only after 3
  - one idle bubble between eop and the next dma_req
- Single-beat transfer: dma_ack, dma_dout_en and dma_dout_eop all high in the same cycle. Required: layer_ack and layer_dout_eop pulse on the next cycle; state returns to IDLE.
- Spurious beat: dma_dout_en=1 while IDLE. Required: no layer_dout_en bit set; err_spurious=1 and stays 1 until reset.
- Async reset asserted mid-XFER (beat 5 of 128). Required: busy, dma_req and all layer vectors 0 immediately; after release, the next grant starts at requester 0.
